toggle_bank_checker: RTL

- Receive-side checker for a bank of per-bit toggle generators. Each generator bit is reset to 0 and then inverts every clock, so the bus alternates all-0 / all-1.
- The checker samples the WIDTH-bit bus and acquires the toggle phase. It then flags any bit that fails to invert, and keeps an error count and a sticky per-bit error mask.
- Used in fault-injection / TMR test benches and on-chip self-test, on the same clock as the generator bank.

---
 rtl/toggle_bank_checker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/toggle_bank_checker.sv
// -----------------------------------------------------------------------------
// toggle_bank_checker
//   Receive-side checker for a bank of per-bit toggle generators. The bus a is
//   expected to alternate all-0 / all-1 every clock. The checker acquires the
//   toggle phase, then flags every cycle in which any bit fails to invert,
//   keeping a saturating error-cycle count and a sticky per-bit error mask.
//
// Ports
//   c        in   clock, rising edge
//   r        in   asynchronous active-low reset
//   en       in   checker enable (0 forces IDLE)
//   clr      in   synchronous clear of err_cnt / err_mask
//   a        in   [WIDTH-1:0] monitored toggle bus
//   locked   out  phase lock acquired
//   err      out  one-cycle pulse per error cycle
//   err_cnt  out  [ERR_CNT_W-1:0] saturating error-cycle count
//   err_mask out  [WIDTH-1:0] sticky OR of mismatching bits
//   coh_err  out  (TOGGLE_BANK_CHECKER_COHERENCE_EN only) bus neither all-0
//                 nor all-1 in ACQUIRE/LOCKED
//
// Optional feature macro: TOGGLE_BANK_CHECKER_COHERENCE_EN
// -----------------------------------------------------------------------------
module toggle_bank_checker #(
    parameter int WIDTH       = 32,
    parameter int LOCK_CYCLES = 4,
    parameter int UNLOCK_ERRS = 2,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 c,
    input  logic                 r,
    input  logic                 en,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     a,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     err_mask
`ifdef TOGGLE_BANK_CHECKER_COHERENCE_EN
    ,
    output logic                 coh_err
`endif
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;

    localparam logic [7:0] LOCK_C   = 8'(LOCK_CYCLES);
    localparam logic [7:0] UNLOCK_C = 8'(UNLOCK_ERRS);

    state_e               state_q, state_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     mask_q, mask_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [7:0]           good_q, good_d;
    logic [7:0]           bad_q, bad_d;
    logic                 valid_q, valid_d;
    logic                 coh_q, coh_d;

    logic [WIDTH-1:0]     mis;
    logic                 incoh;
    logic                 rec;

    assign mis = a ^ exp_q;

`ifdef TOGGLE_BANK_CHECKER_COHERENCE_EN
    assign incoh   = (a != '0) && (a != '1);
    assign coh_err = coh_q;
`else
    assign incoh   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        exp_d    = exp_q;
        good_d   = good_q;
        bad_d    = bad_q;
        valid_d  = valid_q;
        coh_d    = 1'b0;
        rec      = 1'b0;

        case (state_q)
            IDLE: begin
                locked_d = 1'b0;
                if (en) begin
                    state_d = ACQUIRE;
                    valid_d = 1'b0;
                    good_d  = 8'd0;
                end
            end
            ACQUIRE: begin
                // Expected phase follows the bus until lock is declared.
                exp_d   = ~a;
                valid_d = 1'b1;
                coh_d   = incoh;
                if (valid_q && (a == exp_q) && !incoh) good_d = good_q + 8'd1;
                else                                   good_d = 8'd0;
                if (good_d == LOCK_C) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                    bad_d    = 8'd0;
                end
            end
            LOCKED: begin
                // Free-running phase: a glitch does not drag exp along with it.
                exp_d = ~exp_q;
                coh_d = incoh;
                if (mis != '0) begin
                    err_d = 1'b1;
                    rec   = 1'b1;
                    bad_d = bad_q + 8'd1;
                    if (bad_d == UNLOCK_C) begin
                        state_d  = ACQUIRE;
                        locked_d = 1'b0;
                        valid_d  = 1'b0;
                        good_d   = 8'd0;
                        bad_d    = 8'd0;
                    end
                end else begin
                    bad_d = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!en) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            err_d    = 1'b0;
            coh_d    = 1'b0;
            rec      = 1'b0;
        end

        if (rec) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            mask_d = mask_q | mis;
        end

        // Clear wins over an error recorded on the same edge; err still pulses.
        if (clr) begin
            cnt_d  = '0;
            mask_d = '0;
        end
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            mask_q   <= '0;
            exp_q    <= '0;
            good_q   <= 8'd0;
            bad_q    <= 8'd0;
            valid_q  <= 1'b0;
            coh_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            valid_q  <= valid_d;
            coh_q    <= coh_d;
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign err_cnt  = cnt_q;
    assign err_mask = mask_q;

endmodule
